// File: rtl/game_sequencer.sv
// game_sequencer: top-level SuperFrog game FSM.
// Sequences ATTRACT -> START -> PLAY -> DYING -> RESPAWN/OVER and owns lives,
// the saturating score and the meteor fall-speed level.
// Optional feature macro: PAUSE_EN (adds PAUSE state entered/left by start in PLAY).
// All outputs are registered; the FSM state itself is exposed on 'state'.
module game_sequencer #(
  parameter int LIVES       = 3,
  parameter int DIE_FRAMES  = 60,
  parameter int OVER_FRAMES = 300,
  parameter int LEVEL_PTS   = 10,
  parameter int BASE_SPEED  = 1,
  parameter int MAX_SPEED   = 6
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       frame,
  input  logic       btn_start,
  input  logic       collide,
  input  logic       score_tick,
  output logic [2:0] state,
  output logic       run,
  output logic       world_rst,
  output logic       frog_fall,
  output logic       frog_vis,
  output logic [3:0] fall_speed,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_ATTRACT = 3'd0,
    S_START   = 3'd1,
    S_PLAY    = 3'd2,
    S_DYING   = 3'd3,
    S_RESPAWN = 3'd4,
    S_OVER    = 3'd5,
    S_PAUSE   = 3'd6
  } state_t;

  localparam int TW = 16;
  localparam logic [TW-1:0] DIE_LAST  = TW'(DIE_FRAMES);
  localparam logic [TW-1:0] OVER_LAST = TW'(OVER_FRAMES);
  localparam logic [7:0]    LVL_LAST  = 8'(LEVEL_PTS - 1);
  localparam logic [7:0]    SPAN      = 8'(MAX_SPEED - BASE_SPEED);

  state_t          st, st_nx;
  logic [TW-1:0]   timer, timer_nx, timer_inc;
  logic            btn_q;
  logic            start_rise;
  logic [7:0]      level;
  logic [7:0]      lvl_cnt;
  logic [3:0]      speed_nx;

  assign start_rise = btn_start & ~btn_q;
  assign timer_inc  = timer + 1'b1;
  assign state      = st;

  // Speed follows the level counter, clamped at the ceiling.
  assign speed_nx = (level >= SPAN) ? 4'(MAX_SPEED) : 4'(BASE_SPEED) + level[3:0];

  // Next-state and frame-timer logic; a state change always restarts the timer.
  always_comb begin
    st_nx    = st;
    timer_nx = timer;
    case (st)
      S_ATTRACT: if (start_rise) st_nx = S_START;
      S_START:   st_nx = S_PLAY;
      S_PLAY: begin
        if (collide) st_nx = S_DYING;
`ifdef PAUSE_EN
        else if (start_rise) st_nx = S_PAUSE;
`endif
      end
      S_DYING: begin
        if (frame && (timer_inc == DIE_LAST))
          st_nx = (lives == 3'd0) ? S_OVER : S_RESPAWN;
      end
      S_RESPAWN: st_nx = S_PLAY;
      S_OVER: begin
        if (start_rise) st_nx = S_START;
        else if (frame && (timer_inc == OVER_LAST)) st_nx = S_ATTRACT;
      end
`ifdef PAUSE_EN
      S_PAUSE: if (start_rise) st_nx = S_PLAY;
`endif
      default: st_nx = S_ATTRACT;
    endcase
    if (st_nx != st)
      timer_nx = '0;
    else if (frame && ((st == S_DYING) || (st == S_OVER)))
      timer_nx = timer_inc;
  end

  // State register, timer, start-edge sample and registered state-decoded outputs.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      st        <= S_ATTRACT;
      timer     <= '0;
      btn_q     <= 1'b0;
      run       <= 1'b0;
      world_rst <= 1'b0;
      frog_fall <= 1'b0;
      frog_vis  <= 1'b1;
      game_over <= 1'b0;
    end else begin
      st        <= st_nx;
      timer     <= timer_nx;
      btn_q     <= btn_start;
      run       <= (st_nx == S_PLAY);
      world_rst <= (st_nx == S_START) || (st_nx == S_RESPAWN);
      frog_fall <= (st_nx == S_DYING);
      frog_vis  <= (st_nx == S_DYING) ? timer_nx[3] : 1'b1;
      game_over <= (st_nx == S_OVER);
    end
  end

  // Score, level counter, lives and fall speed; only PLAY lets score and lives move.
  always_ff @(posedge clk_pix) begin
    if (rst_pix || (st == S_START)) begin
      score      <= 8'd0;
      level      <= 8'd0;
      lvl_cnt    <= 8'd0;
      lives      <= 3'(LIVES);
      fall_speed <= 4'(BASE_SPEED);
    end else begin
      if ((st == S_PLAY) && score_tick && (score != 8'hFF)) begin
        score <= score + 8'd1;
        if (lvl_cnt == LVL_LAST) begin
          lvl_cnt <= 8'd0;
          level   <= level + 8'd1;
        end else begin
          lvl_cnt <= lvl_cnt + 8'd1;
        end
      end
      if ((st == S_PLAY) && collide)
        lives <= lives - 3'd1;
      fall_speed <= speed_nx;
    end
  end

endmodule
